// File: rtl/power_pkg.sv
// Shared definitions for the power management blocks.
// Contents: default timing constants and the per-domain sequencer state type.
// Optional feature macro used by the sequencer: PDS_RETENTION_EN.
package power_pkg;

  // Default clock-settle and switch-ack timeout budgets, in clk_i cycles.
  localparam int unsigned PDS_SETTLE_CYC  = 4;
  localparam int unsigned PDS_TIMEOUT_CYC = 64;

  // Per-domain sequencer state. PdsPuRestore and PdsPdSave are only reachable
  // when PDS_RETENTION_EN is defined.
  typedef enum logic [3:0] {
    PdsOff       = 4'd0,
    PdsPuWait    = 4'd1,
    PdsPuRestore = 4'd2,
    PdsPuClk     = 4'd3,
    PdsOn        = 4'd4,
    PdsPdClk     = 4'd5,
    PdsPdSave    = 4'd6,
    PdsPdWait    = 4'd7,
    PdsErr       = 4'd8
  } pds_state_e;

endpackage

// File: rtl/pds_domain_fsm.sv
// Single-domain power sequencer: FSM, shared settle/timeout down-counter and
// Moore output decode for one power domain.
// Optional feature macro: PDS_RETENTION_EN (adds restore/save states and ports).
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_on_i           level request for the domain to be powered
//   pu_grant_i         inrush arbiter grant, needed to leave OFF
//   pwr_sw_ack_i       rail-good status from the power switch
//   err_clr_i          pulse clearing a timeout error
//   pu_cand_o          domain is OFF and requesting power-up (arbiter input)
//   pu_wait_o          domain is waiting for power-switch ack (arbiter input)
//   pwr_sw_en_o .. timeout_err_o  sequencing outputs decoded from state
module pds_domain_fsm
  import power_pkg::*;
#(
  parameter int unsigned SETTLE_CYC  = PDS_SETTLE_CYC,
  parameter int unsigned TIMEOUT_CYC = PDS_TIMEOUT_CYC
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_on_i,
  input  logic pu_grant_i,
  input  logic pwr_sw_ack_i,
  input  logic err_clr_i,
  output logic pu_cand_o,
  output logic pu_wait_o,
  output logic pwr_sw_en_o,
  output logic iso_en_o,
  output logic clk_en_o,
  output logic dom_rst_no,
`ifdef PDS_RETENTION_EN
  output logic ret_save_o,
  output logic ret_restore_o,
`endif
  output logic dom_on_o,
  output logic busy_o,
  output logic timeout_err_o
);

  localparam int unsigned CntMax = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  // Loaded with N-1 so the exit happens on the N-th edge spent in the state.
  localparam logic [CntW-1:0] SettleLoad  = CntW'(SETTLE_CYC - 1);
  localparam logic [CntW-1:0] TimeoutLoad = CntW'(TIMEOUT_CYC - 1);

  pds_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PdsOff: begin
        if (req_on_i && pu_grant_i) state_d = PdsPuWait;
      end
      PdsPuWait: begin
        // Ack takes priority over an expiring timeout.
        if (pwr_sw_ack_i) begin
`ifdef PDS_RETENTION_EN
          state_d = PdsPuRestore;
`else
          state_d = PdsPuClk;
`endif
        end else if (cnt_zero) begin
          state_d = PdsErr;
        end
      end
      PdsPuRestore: state_d = PdsPuClk;
      PdsPuClk: begin
        if (cnt_zero) state_d = PdsOn;
      end
      PdsOn: begin
        if (!req_on_i) state_d = PdsPdClk;
      end
      PdsPdClk: begin
        if (cnt_zero) begin
`ifdef PDS_RETENTION_EN
          state_d = PdsPdSave;
`else
          state_d = PdsPdWait;
`endif
        end
      end
      PdsPdSave: state_d = PdsPdWait;
      PdsPdWait: begin
        if (!pwr_sw_ack_i) begin
          state_d = PdsOff;
        end else if (cnt_zero) begin
          state_d = PdsErr;
        end
      end
      PdsErr: begin
        if (err_clr_i) state_d = PdsOff;
      end
      default: state_d = PdsOff;
    endcase
  end

  // Counter saturates at zero and is reloaded whenever a new state is entered.
  always_comb begin
    cnt_d = cnt_zero ? '0 : cnt_q - CntW'(1);
    if (state_d != state_q) begin
      unique case (state_d)
        PdsPuWait, PdsPdWait: cnt_d = TimeoutLoad;
        PdsPuClk, PdsPdClk:   cnt_d = SettleLoad;
        default:              cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PdsOff;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore decode; defaults are the safe (off, isolated, in reset) values.
  always_comb begin
    pwr_sw_en_o   = 1'b0;
    iso_en_o      = 1'b1;
    clk_en_o      = 1'b0;
    dom_rst_no    = 1'b0;
    dom_on_o      = 1'b0;
    busy_o        = 1'b0;
    timeout_err_o = 1'b0;
`ifdef PDS_RETENTION_EN
    ret_save_o    = 1'b0;
    ret_restore_o = 1'b0;
`endif
    unique case (state_q)
      PdsOff: ;
      PdsPuWait: begin
        pwr_sw_en_o = 1'b1;
        busy_o      = 1'b1;
      end
      PdsPuRestore: begin
        pwr_sw_en_o   = 1'b1;
        busy_o        = 1'b1;
`ifdef PDS_RETENTION_EN
        ret_restore_o = 1'b1;
`endif
      end
      PdsPuClk: begin
        pwr_sw_en_o = 1'b1;
        iso_en_o    = 1'b0;
        clk_en_o    = 1'b1;
        busy_o      = 1'b1;
      end
      PdsOn: begin
        pwr_sw_en_o = 1'b1;
        iso_en_o    = 1'b0;
        clk_en_o    = 1'b1;
        dom_rst_no  = 1'b1;
        dom_on_o    = 1'b1;
      end
      PdsPdClk: begin
        pwr_sw_en_o = 1'b1;
        iso_en_o    = 1'b0;
        dom_rst_no  = 1'b1;
        busy_o      = 1'b1;
      end
      PdsPdSave: begin
        pwr_sw_en_o = 1'b1;
        busy_o      = 1'b1;
`ifdef PDS_RETENTION_EN
        ret_save_o  = 1'b1;
`endif
      end
      PdsPdWait: busy_o = 1'b1;
      PdsErr:    timeout_err_o = 1'b1;
      default: ;
    endcase
  end

  assign pu_cand_o = (state_q == PdsOff) && req_on_i;
  assign pu_wait_o = (state_q == PdsPuWait);

endmodule

// File: rtl/power_domain_sequencer.sv
// Multi-domain power sequencer top level: one pds_domain_fsm per domain plus a
// round-robin inrush arbiter bounding how many domains wait for switch ack.
// Optional feature macro: PDS_RETENTION_EN (adds ret_save_o / ret_restore_o).
// Ports (all per-domain vectors are NUM_DOMAINS wide):
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   req_on_i            level power request per domain
//   pwr_sw_ack_i        power-switch rail-good status
//   err_clr_i           timeout error clear pulse
//   pwr_sw_en_o, iso_en_o, clk_en_o, dom_rst_no   sequencing controls
//   ret_save_o, ret_restore_o                     retention pulses (macro only)
//   dom_on_o, busy_o, timeout_err_o               status
module power_domain_sequencer
  import power_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS       = 4,
  parameter int unsigned MAX_CONCURRENT_PU = 1,
  parameter int unsigned SETTLE_CYC        = PDS_SETTLE_CYC,
  parameter int unsigned TIMEOUT_CYC       = PDS_TIMEOUT_CYC
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_DOMAINS-1:0] req_on_i,
  input  logic [NUM_DOMAINS-1:0] pwr_sw_ack_i,
  input  logic [NUM_DOMAINS-1:0] err_clr_i,
  output logic [NUM_DOMAINS-1:0] pwr_sw_en_o,
  output logic [NUM_DOMAINS-1:0] iso_en_o,
  output logic [NUM_DOMAINS-1:0] clk_en_o,
  output logic [NUM_DOMAINS-1:0] dom_rst_no,
`ifdef PDS_RETENTION_EN
  output logic [NUM_DOMAINS-1:0] ret_save_o,
  output logic [NUM_DOMAINS-1:0] ret_restore_o,
`endif
  output logic [NUM_DOMAINS-1:0] dom_on_o,
  output logic [NUM_DOMAINS-1:0] busy_o,
  output logic [NUM_DOMAINS-1:0] timeout_err_o
);

  localparam int unsigned PtrW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  logic [PtrW-1:0]        ptr_q, ptr_d;
  logic [NUM_DOMAINS-1:0] pu_cand, pu_wait, pu_grant;

  // Round-robin inrush arbiter: hand out the free PU_WAIT slots to requesting
  // OFF domains starting at the pointer; the pointer moves past the last grant.
  always_comb begin
    int unsigned wait_cnt;
    int unsigned avail;
    int unsigned idx;
    wait_cnt = 0;
    for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
      wait_cnt += 32'(pu_wait[i]);
    end
    avail    = (wait_cnt >= MAX_CONCURRENT_PU) ? 0 : MAX_CONCURRENT_PU - wait_cnt;
    pu_grant = '0;
    ptr_d    = ptr_q;
    for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_DOMAINS) idx -= NUM_DOMAINS;
      if (pu_cand[idx[PtrW-1:0]] && (avail != 0)) begin
        pu_grant[idx[PtrW-1:0]] = 1'b1;
        avail = avail - 1;
        ptr_d = (idx == NUM_DOMAINS - 1) ? '0 : PtrW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_dom
    pds_domain_fsm #(
      .SETTLE_CYC  (SETTLE_CYC),
      .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_fsm (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .req_on_i      (req_on_i[d]),
      .pu_grant_i    (pu_grant[d]),
      .pwr_sw_ack_i  (pwr_sw_ack_i[d]),
      .err_clr_i     (err_clr_i[d]),
      .pu_cand_o     (pu_cand[d]),
      .pu_wait_o     (pu_wait[d]),
      .pwr_sw_en_o   (pwr_sw_en_o[d]),
      .iso_en_o      (iso_en_o[d]),
      .clk_en_o      (clk_en_o[d]),
      .dom_rst_no    (dom_rst_no[d]),
`ifdef PDS_RETENTION_EN
      .ret_save_o    (ret_save_o[d]),
      .ret_restore_o (ret_restore_o[d]),
`endif
      .dom_on_o      (dom_on_o[d]),
      .busy_o        (busy_o[d]),
      .timeout_err_o (timeout_err_o[d])
    );
  end

endmodule

// File: tb/tb_power_domain_sequencer.sv
// Randomized bench for power_domain_sequencer. A reference model tracks each
// domain's phase with elapsed-time bookkeeping and pushes the expected output
// snapshot per clock into a queue; a monitor pops and compares on the falling
// edge. Honours PDS_RETENTION_EN when defined.
module tb_power_domain_sequencer;

  localparam int unsigned N    = 4;
  localparam int unsigned MAXC = 1;
  localparam int unsigned S    = 4;
  localparam int unsigned T    = 16;
  localparam int          RUN_CYC = 4000;

  // Model phases.
  localparam int PhOff = 0, PhUpWait = 1, PhRestore = 2, PhUpClk = 3, PhOn = 4;
  localparam int PhDnClk = 5, PhSave = 6, PhDnWait = 7, PhErr = 8;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic [N-1:0] req_on_i = '0;
  logic [N-1:0] pwr_sw_ack_i = '0;
  logic [N-1:0] err_clr_i = '0;
  logic [N-1:0] pwr_sw_en_o, iso_en_o, clk_en_o, dom_rst_no;
  logic [N-1:0] dom_on_o, busy_o, timeout_err_o;
`ifdef PDS_RETENTION_EN
  logic [N-1:0] ret_save_o, ret_restore_o;
`endif

  always #5 clk_i = ~clk_i;

  power_domain_sequencer #(
    .NUM_DOMAINS       (N),
    .MAX_CONCURRENT_PU (MAXC),
    .SETTLE_CYC        (S),
    .TIMEOUT_CYC       (T)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_on_i      (req_on_i),
    .pwr_sw_ack_i  (pwr_sw_ack_i),
    .err_clr_i     (err_clr_i),
    .pwr_sw_en_o   (pwr_sw_en_o),
    .iso_en_o      (iso_en_o),
    .clk_en_o      (clk_en_o),
    .dom_rst_no    (dom_rst_no),
`ifdef PDS_RETENTION_EN
    .ret_save_o    (ret_save_o),
    .ret_restore_o (ret_restore_o),
`endif
    .dom_on_o      (dom_on_o),
    .busy_o        (busy_o),
    .timeout_err_o (timeout_err_o)
  );

  typedef struct packed {
    logic [N-1:0] sw, iso, clk, rst, on, busy, err, save, rest;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Expected outputs per phase: {sw, iso, clk, rst, on, busy, err, save, restore}.
  function automatic logic [8:0] ph_out(input int ph);
    case (ph)
      PhOff:     return 9'b0_1_0_0_0_0_0_0_0;
      PhUpWait:  return 9'b1_1_0_0_0_1_0_0_0;
      PhRestore: return 9'b1_1_0_0_0_1_0_0_1;
      PhUpClk:   return 9'b1_0_1_0_0_1_0_0_0;
      PhOn:      return 9'b1_0_1_1_1_0_0_0_0;
      PhDnClk:   return 9'b1_0_0_1_0_1_0_0_0;
      PhSave:    return 9'b1_1_0_0_0_1_0_1_0;
      PhDnWait:  return 9'b0_1_0_0_0_1_0_0_0;
      default:   return 9'b0_1_0_0_0_0_1_0_0;
    endcase
  endfunction

  // ---------------- reference model ----------------
  int     ph  [N];
  longint ent [N];
  int     ptr;
  longint cyc;

  always @(posedge clk_i) begin
    obs_t         e;
    int           nph [N];
    logic [N-1:0] g;
    logic [8:0]   o;
    int           avail, last, idx;
    longint       el;
    if (!rst_ni) begin
      for (int d = 0; d < N; d++) begin
        ph[d]  = PhOff;
        ent[d] = 0;
      end
      ptr = 0;
      cyc = 0;
    end else begin
      cyc++;
      avail = MAXC;
      for (int d = 0; d < N; d++) if (ph[d] == PhUpWait) avail--;
      g    = '0;
      last = -1;
      for (int k = 0; k < N; k++) begin
        idx = (ptr + k) % N;
        if (avail > 0 && ph[idx] == PhOff && req_on_i[idx]) begin
          g[idx] = 1'b1;
          avail--;
          last = idx;
        end
      end
      if (last >= 0) ptr = (last + 1) % N;
      for (int d = 0; d < N; d++) begin
        el     = cyc - ent[d];
        nph[d] = ph[d];
        case (ph[d])
          PhOff:     if (g[d]) nph[d] = PhUpWait;
          PhUpWait: begin
            if (pwr_sw_ack_i[d]) begin
`ifdef PDS_RETENTION_EN
              nph[d] = PhRestore;
`else
              nph[d] = PhUpClk;
`endif
            end else if (el >= T) nph[d] = PhErr;
          end
          PhRestore: nph[d] = PhUpClk;
          PhUpClk:   if (el >= S) nph[d] = PhOn;
          PhOn:      if (!req_on_i[d]) nph[d] = PhDnClk;
          PhDnClk: begin
            if (el >= S) begin
`ifdef PDS_RETENTION_EN
              nph[d] = PhSave;
`else
              nph[d] = PhDnWait;
`endif
            end
          end
          PhSave:    nph[d] = PhDnWait;
          PhDnWait: begin
            if (!pwr_sw_ack_i[d]) nph[d] = PhOff;
            else if (el >= T) nph[d] = PhErr;
          end
          default:   if (err_clr_i[d]) nph[d] = PhOff;
        endcase
      end
      for (int d = 0; d < N; d++) begin
        if (nph[d] != ph[d]) ent[d] = cyc;
        ph[d] = nph[d];
      end
    end
    for (int d = 0; d < N; d++) begin
      o         = ph_out(ph[d]);
      e.sw[d]   = o[8];
      e.iso[d]  = o[7];
      e.clk[d]  = o[6];
      e.rst[d]  = o[5];
      e.on[d]   = o[4];
      e.busy[d] = o[3];
      e.err[d]  = o[2];
      e.save[d] = o[1];
      e.rest[d] = o[0];
    end
    exp_q.push_back(e);
  end

  // ---------------- monitor ----------------
  always @(negedge clk_i) begin
    obs_t got, want;
    if (exp_q.size() > 0) begin
      want     = exp_q.pop_front();
      got.sw   = pwr_sw_en_o;
      got.iso  = iso_en_o;
      got.clk  = clk_en_o;
      got.rst  = dom_rst_no;
      got.on   = dom_on_o;
      got.busy = busy_o;
      got.err  = timeout_err_o;
`ifdef PDS_RETENTION_EN
      got.save = ret_save_o;
      got.rest = ret_restore_o;
`else
      got.save = '0;
      got.rest = '0;
`endif
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL outputs t=%0t got sw=%b iso=%b clk=%b rst=%b on=%b busy=%b err=%b sv=%b rs=%b | want sw=%b iso=%b clk=%b rst=%b on=%b busy=%b err=%b sv=%b rs=%b",
                 $time, got.sw, got.iso, got.clk, got.rst, got.on, got.busy, got.err,
                 got.save, got.rest, want.sw, want.iso, want.clk, want.rst, want.on,
                 want.busy, want.err, want.save, want.rest);
      end
    end
  end

  // ---------------- stimulus and power-switch emulation ----------------
  int unsigned lag [N];

  // Mostly quick acks, plus delays around and beyond the timeout boundary.
  function automatic int unsigned pick_lag();
    int unsigned r;
    r = $urandom_range(0, 9);
    case (r)
      6:       return 14;
      7:       return T - 1;
      8:       return T;
      9:       return 20;
      default: return r;
    endcase
  endfunction

  initial begin
    for (int d = 0; d < N; d++) lag[d] = 0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (10) @(negedge clk_i);
    n_cmp++;
    if (iso_en_o !== 4'hF || pwr_sw_en_o !== '0 || clk_en_o !== '0 || dom_rst_no !== '0 ||
        dom_on_o !== '0 || busy_o !== '0 || timeout_err_o !== '0
`ifdef PDS_RETENTION_EN
        || ret_save_o !== '0 || ret_restore_o !== '0
`endif
        ) begin
      n_bad++;
      $display("FAIL reset state t=%0t sw=%b iso=%b clk=%b rst=%b on=%b busy=%b err=%b",
               $time, pwr_sw_en_o, iso_en_o, clk_en_o, dom_rst_no, dom_on_o, busy_o,
               timeout_err_o);
    end
    req_on_i[1] = 1'b1;
    repeat (20) @(negedge clk_i);
    n_cmp++;
    if (timeout_err_o[1] !== 1'b1 || pwr_sw_en_o[1] !== 1'b0 || iso_en_o[1] !== 1'b1 ||
        clk_en_o[1] !== 1'b0 || dom_rst_no[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL expired wait t=%0t err=%b sw=%b iso=%b clk=%b rst=%b",
               $time, timeout_err_o[1], pwr_sw_en_o[1], iso_en_o[1], clk_en_o[1],
               dom_rst_no[1]);
    end
    req_on_i[1]  = 1'b0;
    err_clr_i[1] = 1'b1;
    @(negedge clk_i);
    err_clr_i[1] = 1'b0;
    for (int c = 0; c < RUN_CYC; c++) begin
      @(negedge clk_i);
      err_clr_i = '0;
      for (int d = 0; d < N; d++) begin
        if ($urandom_range(0, 19) == 0) req_on_i[d] = ~req_on_i[d];
        if ($urandom_range(0, 5) == 0) err_clr_i[d] = 1'b1;
        if (pwr_sw_en_o[d] != pwr_sw_ack_i[d]) begin
          if (lag[d] == 0) pwr_sw_ack_i[d] = pwr_sw_en_o[d];
          else lag[d] = lag[d] - 1;
        end else begin
          lag[d] = pick_lag();
        end
      end
    end
    repeat (3) @(negedge clk_i);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/power_domain_sequencer.md
# power_domain_sequencer

Parametrised multi-domain power sequencer that turns per-domain on/off requests into ordered power-switch, isolation, retention, clock-enable and reset sequences. It replaces fixed per-domain enables with handshaked sequencing, inrush limiting and timeout detection. It sits between the power management policy logic (state machine and CSRs) and the physical power-switch/isolation cells of each core, cache and interconnect domain.

## Interface
- NUM_DOMAINS, 4: number of independently sequenced domains (1..32)
- MAX_CONCURRENT_PU, 1: maximum domains simultaneously waiting for power-switch ack during power-up (1..NUM_DOMAINS)
- SETTLE_CYC, 4: clock settle cycles in the clock stages (>=1)
- TIMEOUT_CYC, 64: cycles allowed for a switch ack before error (>=2)

- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_on_i  in  NUM_DOMAINS  level request: 1 = domain wanted powered
- pwr_sw_ack_i  in  NUM_DOMAINS  power-switch status from the domain (1 = rail good)
- err_clr_i  in  NUM_DOMAINS  one-cycle pulse that clears a domain's error
- pwr_sw_en_o  out  NUM_DOMAINS  power-switch enable
- iso_en_o  out  NUM_DOMAINS  isolation enable (1 = isolated)
- clk_en_o  out  NUM_DOMAINS  domain clock enable
- dom_rst_no  out  NUM_DOMAINS  domain reset, active-low
- ret_save_o  out  NUM_DOMAINS  retention save pulse (present only with PDS_RETENTION_EN)
- ret_restore_o  out  NUM_DOMAINS  retention restore pulse (present only with PDS_RETENTION_EN)
- dom_on_o  out  NUM_DOMAINS  domain fully on
- busy_o  out  NUM_DOMAINS  domain mid-sequence
- timeout_err_o  out  NUM_DOMAINS  sticky per-domain timeout error

## Operation
- Each domain has an independent FSM with states OFF, PU_WAIT, PU_RESTORE, PU_CLK, ON, PD_CLK, PD_SAVE, PD_WAIT, ERR. All outputs are Moore outputs decoded from registered state.
- OFF: sw_en=0, iso=1, clk_en=0, rst_no=0. If req_on=1 and the domain holds a power-up grant, go to PU_WAIT.
- PU_WAIT: sw_en=1. When ack=1, go to PU_RESTORE. If the counter reaches TIMEOUT_CYC first, go to ERR.
- PU_RESTORE: ret_restore=1 for exactly one cycle, then go to PU_CLK.
- PU_CLK: iso=0, clk_en=1, rst_no=0. Hold for SETTLE_CYC cycles, then go to ON.
- ON: rst_no=1, dom_on=1. If req_on=0, go to PD_CLK.
- PD_CLK: clk_en=0, iso=0, rst_no=1. Hold for SETTLE_CYC cycles, then go to PD_SAVE.
- PD_SAVE: iso=1, ret_save=1 for exactly one cycle, rst_no=0, then go to PD_WAIT.
- PD_WAIT: sw_en=0. When ack=0, go to OFF. If the counter reaches TIMEOUT_CYC first, go to ERR.
- ERR: sw_en=0, iso=1, clk_en=0, rst_no=0, timeout_err=1. On err_clr go to OFF and clear the error. A new request is accepted only after err_clr.
- req_on is sampled only in OFF and ON. Changes during a sequence are ignored until the sequence reaches OFF or ON; the level then decides the next step.
- busy=1 in every state except OFF, ON and ERR.
- Inrush arbiter: round-robin over domains in OFF with req_on=1. Grants at most MAX_CONCURRENT_PU minus the count currently in PU_WAIT per cycle. The pointer advances past the last granted index. Power-down is never limited.
- Each domain has one shared down-counter of width $clog2(max(SETTLE_CYC,TIMEOUT_CYC)+1). It is loaded on state entry and saturates at 0.

## Timing
- Reset (async assert, sync deassert handled upstream): all domains OFF; sw_en=0, iso=1, clk_en=0, rst_no=0, ret pulses 0, dom_on=0, busy=0, timeout_err=0; arbiter pointer=0.
- Power-up: req_on seen at edge k with grant gives sw_en=1 after edge k.
- ack seen at edge m gives ret_restore high for the cycle after m (with the macro). clk_en rises one cycle later, or directly after m without the macro.
- rst_no rises SETTLE_CYC cycles after clk_en rises.
- Power-down: req_on=0 seen in ON at edge k gives clk_en=0 after k.
- iso=1 and rst_no=0 follow SETTLE_CYC cycles after clk_en falls. sw_en=0 follows one cycle later.
- Timeout: ERR is entered on the edge where the counter has spent TIMEOUT_CYC cycles in a wait state without ack.
- If ack and timeout expire in the same cycle, ack wins.
- If err_clr arrives outside ERR, it has no effect.

## Configuration
- PDS_RETENTION_EN defined: PU_RESTORE and PD_SAVE exist, and the ret_save_o/ret_restore_o ports are present.
- Undefined: both states are bypassed and the ports are removed. Power-up goes PU_WAIT to PU_CLK; power-down goes PD_CLK to PD_WAIT, with iso=1 and rst_no=0 asserted on entry to PD_WAIT.

## Structure
- power_pkg gains pds_state_e (the state enum) and the default constants PDS_SETTLE_CYC and PDS_TIMEOUT_CYC.
- One sub-module, pds_domain_fsm, holds the per-domain FSM, counter and output decode. It is instantiated NUM_DOMAINS times in a generate loop.
- The top level holds the round-robin inrush arbiter.

## Test plan
All scenarios use NUM_DOMAINS=4, MAX_CONCURRENT_PU=1, SETTLE_CYC=4, TIMEOUT_CYC=16.
- Reset check: reset, then idle 10 cycles -> iso_en_o=4'hF, all other outputs 0.
- Single power-up: req_on[0]=1, ack returned 3 cycles after sw_en -> sw_en[0] next cycle; clk_en[0] 1 cycle after ack (2 with the macro, preceded by ret_restore pulse); dom_rst_no[0] 4 cycles later; dom_on[0]=1.
- Inrush limit: req_on=4'hF at once, ack after 5 cycles each -> sw_en rises one domain at a time in order 0,1,2,3; never two domains in PU_WAIT simultaneously.
- Power-down: drop req_on[2] while ON, ack falls 2 cycles after sw_en drops -> clk_en[2]=0 first; iso[2]=1 and rst_no[2]=0 4 cycles later; sw_en[2]=0 next; busy[2] falls on OFF.
- Timeout and recovery: ack[1] held 0 -> timeout_err[1]=1 after 16 cycles in PU_WAIT with all domain-1 outputs safe; req_on stays 1 and err_clr[1] pulses -> domain 1 restarts power-up.
- Mid-sequence change: req_on[3] toggled 1 then 0 during PU_CLK -> domain 3 reaches ON, then immediately enters PD_CLK.
